mul_unit: RTL and testbench

- Multi-cycle radix-2 shift-add multiplier. It implements the MUL, MULH and MULHU operations, whose encodings the ALU reserves but does not compute.
- Sits beside the ALU in the execute stage and takes the same rs1/rs2 operands and 4-bit op select.
- The control path stalls the PC while busy is high, then muxes mul_out into writeback on done.

---
 rtl/mul_unit.sv | 129 ++++++++++++
 tb/tb_mul_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// Multi-cycle radix-2 shift-add multiplier for MUL / MULH / MULHU.
// Operands are latched on accept as magnitudes with a separate sign flag.
// One shift-add step runs per CALC cycle. A final CALC cycle applies the
// sign and registers the selected product half into mul_out.
module mul_unit #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] OP_MUL   = 4'd10,
  parameter logic [3:0] OP_MULH  = 4'd11,
  parameter logic [3:0] OP_MULHU = 4'd12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       mul_sel,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mul_out
);

  // The counter reaches WIDTH. Counts 0..WIDTH-1 are the shift-add
  // iterations, and count WIDTH is the finalize step that writes mul_out.
  localparam int                   CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   ONE_2W   = (2 * WIDTH)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_prod;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;
  logic                 r_op_low;
  logic [WIDTH-1:0]     r_mul_out;

  logic                 w_valid_op;
  logic                 w_accept;
  logic                 w_is_signed;
  logic                 w_last;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_prod_step;
  logic [2*WIDTH-1:0]   w_prod_final;

  // Unsigned magnitude of a signed operand. The most negative value negates
  // to itself, which reads correctly as the unsigned value 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] fn_mag(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return (v < 0) ? (~u + ONE_W) : u;
  endfunction

  // Conditional two's-complement negation of the full-width product, mod 2^(2W).
  function automatic logic [2*WIDTH-1:0] fn_apply_sign(input logic [2*WIDTH-1:0] p,
                                                       input logic               neg);
    return neg ? (~p + ONE_2W) : p;
  endfunction

  assign w_valid_op   = (mul_sel == OP_MUL) || (mul_sel == OP_MULH) || (mul_sel == OP_MULHU);
  assign w_accept     = (r_state == S_IDLE) && start && w_valid_op;
  assign w_is_signed  = (mul_sel != OP_MULHU);
  assign w_last       = (r_cnt == LAST_CNT);

  assign w_sum        = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                      + {1'b0, (r_mplier[0] ? r_mcand : '0)};
  assign w_prod_step  = {w_sum, r_prod[WIDTH-1:1]};
  assign w_prod_final = fn_apply_sign(r_prod, r_neg);

  // Next-state decode for IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
      S_CALC:  if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand latch on accept, shift-add iterations, and the final result write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_op_low  <= 1'b0;
      r_mul_out <= '0;
    end else if (w_accept) begin
      r_mcand   <= w_is_signed ? fn_mag(rs1_data) : rs1_data;
      r_mplier  <= w_is_signed ? fn_mag(rs2_data) : rs2_data;
      r_neg     <= w_is_signed & (rs1_data[WIDTH-1] ^ rs2_data[WIDTH-1]);
      r_op_low  <= (mul_sel == OP_MUL);
      r_prod    <= '0;
      r_cnt     <= '0;
    end else if (r_state == S_CALC) begin
      if (!w_last) begin
        r_prod   <= w_prod_step;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_ONE;
      end else begin
        r_mul_out <= r_op_low ? w_prod_final[WIDTH-1:0]
                              : w_prod_final[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign mul_out = r_mul_out;

endmodule

// File: tb/tb_mul_unit.sv
// Testbench for mul_unit. Stimulus pushes expected results into a queue, and
// a monitor pops and compares them on every done pulse.
module tb_mul_unit;

  localparam int         WIDTH    = 32;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULH  = 4'd11;
  localparam logic [3:0] OP_MULHU = 4'd12;
  localparam int         LATENCY  = 33;
  localparam int         PERIOD   = 35;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       mul_sel;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] mul_out;

  typedef struct {
    logic [31:0] val;
    int          acc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          n_cmp    = 0;
  int          n_fail   = 0;
  logic [31:0] last_out = '0;

  mul_unit #(
    .WIDTH(WIDTH), .OP_MUL(OP_MUL), .OP_MULH(OP_MULH), .OP_MULHU(OP_MULHU)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mul_sel(mul_sel),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .busy(busy), .done(done), .mul_out(mul_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain 64-bit arithmetic on the operand values.
  function automatic logic [31:0] ref_mul(input logic [3:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    longint     sp;
    logic [63:0] spb;
    logic [63:0] up;
    sp  = longint'($signed(a)) * longint'($signed(b));
    spb = sp;
    up  = {32'd0, a} * {32'd0, b};
    case (sel)
      OP_MUL:  return spb[31:0];
      OP_MULH: return spb[63:32];
      default: return up[63:32];
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  task automatic push_exp(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input string nm);
    exp_t e;
    e.val  = ref_mul(sel, a, b);
    e.acc  = cyc;
    e.name = nm;
    sb.push_back(e);
    last_out = e.val;
  endtask

  task automatic wait_done(input int tgt, input int budget, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= tgt) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: done count %0d, expected %0d", nm, done_cnt, tgt);
    end
  endtask

  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input string nm);
    int tgt;
    @(negedge clk);
    start = 1'b1; mul_sel = sel; rs1_data = a; rs2_data = b;
    @(posedge clk); #1;
    push_exp(sel, a, b, nm);
    tgt = done_cnt + 1;
    start    = 1'b0;
    rs1_data = $urandom;
    rs2_data = $urandom;
    mul_sel  = 4'($urandom_range(0, 15));
    chk({nm, "_busy_after_accept"}, 32'(busy), 32'd1);
    wait_done(tgt, 60, nm);
    chk({nm, "_busy_after_done"}, 32'(busy), 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending result", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_value"}, mul_out, mon_e.val);
        chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc), 32'(LATENCY));
        chk({mon_e.name, "_busy_in_done"}, 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, pick;
    logic [3:0]  sel;
    int          tgt, base;
    bit          ok;

    rst = 1'b1; start = 1'b0; mul_sel = '0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_mul_out", mul_out, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Directed corner cases
    run_op(OP_MUL,   32'd7,          32'd6,          "mul_7x6");
    run_op(OP_MULH,  32'h8000_0000,  32'h8000_0000,  "mulh_min_min");
    run_op(OP_MUL,   32'h8000_0000,  32'h8000_0000,  "mul_min_min");
    run_op(OP_MULHU, 32'h8000_0000,  32'h8000_0000,  "mulhu_min_min");
    run_op(OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  "mulhu_ones");
    run_op(OP_MULH,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  "mulh_m1_m1");
    run_op(OP_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  "mul_m1_m1");
    run_op(OP_MULH,  32'hFFFF_FFFD,  32'd5,          "mulh_m3_5");
    run_op(OP_MUL,   32'hFFFF_FFFD,  32'd5,          "mul_m3_5");
    run_op(OP_MULHU, 32'hFFFF_FFFD,  32'd5,          "mulhu_m3_5");

    // Randomized operations with occasional corner operands
    for (int i = 0; i < 12; i++) begin
      sel  = 4'(OP_MUL + 4'($urandom_range(0, 2)));
      pick = $urandom_range(0, 5);
      case (pick)
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(sel, a, b, "rand_op");
    end

    // Start and operand changes while busy are ignored
    @(negedge clk);
    start = 1'b1; mul_sel = OP_MUL; rs1_data = 32'h1234_5678; rs2_data = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    push_exp(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, "busy_ignore");
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; mul_sel = OP_MULHU; rs1_data = $urandom; rs2_data = $urandom;
    repeat (3) @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL busy_ignore_timeout: done never seen, expected a pulse");
    end
    // Start presented only during the DONE cycle must not be accepted
    start = 1'b1; mul_sel = OP_MUL; rs1_data = 32'd5; rs2_data = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("start_in_done_busy2", 32'(busy), 32'd0);
    chk("start_in_done_done", 32'(done), 32'd0);

    // Start with a non-multiply op select is ignored
    @(negedge clk);
    start = 1'b1; mul_sel = 4'd2; rs1_data = 32'd9; rs2_data = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("add_sel_busy", 32'(busy), 32'd0);
      chk("add_sel_done", 32'(done), 32'd0);
      chk("add_sel_mul_out", mul_out, last_out);
      @(posedge clk); #1;
    end

    // Reset in the middle of CALC aborts without a done pulse
    @(negedge clk);
    start = 1'b1; mul_sel = OP_MUL; rs1_data = 32'd3; rs2_data = 32'd3;
    @(posedge clk); #1;
    push_exp(OP_MUL, 32'd3, 32'd3, "aborted");
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    base = done_cnt;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mul_out", mul_out, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(base));

    // Start held high continuously: accepts follow at the fixed period
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; mul_sel = OP_MULH; rs1_data = $urandom; rs2_data = $urandom;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) @(posedge clk);
      else        repeat (PERIOD) @(posedge clk);
      #1;
      push_exp(mul_sel, rs1_data, rs2_data, "back_to_back");
      if (k == 3) start = 1'b0;
      mul_sel  = 4'(OP_MUL + 4'($urandom_range(0, 2)));
      rs1_data = $urandom;
      rs2_data = $urandom;
    end
    wait_done(base + 4, 60, "back_to_back");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
